// File: rtl/mii_hex_dumper.sv
// MII byte capture FIFO feeding a byte-wide UART, emitting raw bytes or a lowercase hex dump.
// Define HEXDUMP_EOF_EN to store the frame-end tag with each byte and break hex lines on it.
module mii_hex_dumper #(
  parameter int unsigned DEPTH_LOG2     = 6,
  parameter int unsigned BYTES_PER_LINE = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_rdy,
  input  logic [7:0]            in_d,
  input  logic                  in_eof,
  input  logic                  hex_mode,
  output logic                  tx_dv,
  output logic [7:0]            tx_d,
  input  logic                  tx_active,
  output logic [DEPTH_LOG2:0]   fill,
  output logic                  overflow,
  output logic [15:0]           drop_count
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
`ifdef HEXDUMP_EOF_EN
  localparam int unsigned EW = 9;
`else
  localparam int unsigned EW = 8;
`endif
  localparam logic [7:0] CHAR_SP = 8'h20;
  localparam logic [7:0] CHAR_CR = 8'h0d;
  localparam logic [7:0] CHAR_LF = 8'h0a;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_HI, WAIT_LO, NEXT} state_t;
  typedef enum logic [1:0] {CH_HI, CH_LO, CH_CR, CH_END} char_t;

  logic [EW-1:0]       mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr, rd_ptr;
  logic                rdy_q, cap, full, empty, wr_en, pop;
  logic [EW-1:0]       wr_entry;
  logic [8:0]          rd_entry;
  state_t              state, state_n;
  char_t               ch_r, ch_n;
  logic [7:0]          byte_r, tx_d_n, line_cnt, line_n;
  logic                eof_r, mode_r, eol;

  assign cap   = in_rdy & ~rdy_q;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                 (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign wr_en = cap & ~full;
  assign fill  = wr_ptr - rd_ptr;

`ifdef HEXDUMP_EOF_EN
  assign wr_entry = {in_eof, in_d};
  assign rd_entry = mem[rd_ptr[DEPTH_LOG2-1:0]];
`else
  logic unused_eof;
  assign unused_eof = in_eof;
  assign wr_entry   = in_d;
  assign rd_entry   = {1'b0, mem[rd_ptr[DEPTH_LOG2-1:0]]};
`endif

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_entry;
  end

  // Full is taken from the pre-pop pointers, so a capture at full is dropped even on a pop cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy_q      <= 1'b0;
      wr_ptr     <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      rdy_q <= in_rdy;
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (cap && full) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr   <= '0;
      state    <= IDLE;
      ch_r     <= CH_HI;
      tx_d     <= '0;
      line_cnt <= '0;
      byte_r   <= '0;
      eof_r    <= 1'b0;
      mode_r   <= 1'b0;
    end else begin
      if (pop) begin
        rd_ptr          <= rd_ptr + PTR_ONE;
        {eof_r, byte_r} <= rd_entry;
        mode_r          <= hex_mode;
      end
      state    <= state_n;
      ch_r     <= ch_n;
      tx_d     <= tx_d_n;
      line_cnt <= line_n;
    end
  end

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h57 + {4'h0, n};
  endfunction

  assign eol   = eof_r | (({1'b0, line_cnt} + 9'd1) == 9'(BYTES_PER_LINE));
  assign tx_dv = (state == SEND) & ~tx_active;

  always_comb begin
    state_n = state;
    ch_n    = ch_r;
    tx_d_n  = tx_d;
    line_n  = line_cnt;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !tx_active) begin
          pop     = 1'b1;
          state_n = LOAD;
        end
      end
      LOAD: begin
        tx_d_n  = mode_r ? hex_char(byte_r[7:4]) : byte_r;
        ch_n    = CH_HI;
        state_n = SEND;
      end
      SEND:    if (!tx_active) state_n = WAIT_HI;
      WAIT_HI: if (tx_active)  state_n = WAIT_LO;
      WAIT_LO: if (!tx_active) state_n = NEXT;
      NEXT: begin
        state_n = SEND;
        if (!mode_r) begin
          state_n = IDLE;
        end else begin
          case (ch_r)
            CH_HI: begin
              tx_d_n = hex_char(byte_r[3:0]);
              ch_n   = CH_LO;
            end
            CH_LO: begin
              if (eol) begin
                tx_d_n = CHAR_CR;
                ch_n   = CH_CR;
                line_n = '0;
              end else begin
                tx_d_n = CHAR_SP;
                ch_n   = CH_END;
                line_n = line_cnt + 8'd1;
              end
            end
            CH_CR: begin
              tx_d_n = CHAR_LF;
              ch_n   = CH_END;
            end
            default: state_n = IDLE;
          endcase
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mii_hex_dumper.sv
// Bench for mii_hex_dumper: vector table, timing/overflow/reset sequences, randomized bursts vs a formatter model.
module tb_mii_hex_dumper;
  localparam int unsigned DL2 = 2;
  localparam int unsigned BPL = 2;
`ifdef HEXDUMP_EOF_EN
  localparam bit EOF_EN = 1'b1;
`else
  localparam bit EOF_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset, in_rdy, in_eof, hex_mode, tx_dv, tx_active, overflow;
  logic [7:0]      in_d, tx_d;
  logic [DL2:0]    fill;
  logic [15:0]     drop_count;

  int              n_tests = 0;
  int              n_fail  = 0;
  logic [7:0]      rx[$];
  logic [7:0]      exp_q[$];
  int unsigned     m_line = 0;
  bit              hold_busy = 1'b0;
  int unsigned     busy_len = 3;
  string           hexdig = "0123456789abcdef";

  typedef struct {
    logic [7:0]  d;
    bit          eof;
    bit          hex;
    int unsigned n;
    logic [31:0] chars;
  } vec_t;
  vec_t vecs[12];

  always #5 clk = ~clk;

  mii_hex_dumper #(.DEPTH_LOG2(DL2), .BYTES_PER_LINE(BPL)) dut (
    .clk(clk), .reset(reset), .in_rdy(in_rdy), .in_d(in_d), .in_eof(in_eof),
    .hex_mode(hex_mode), .tx_dv(tx_dv), .tx_d(tx_d), .tx_active(tx_active),
    .fill(fill), .overflow(overflow), .drop_count(drop_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && tx_dv) begin
      rx.push_back(tx_d);
      check("dv_while_busy", {31'd0, tx_active}, 32'd0);
    end
  end

  // UART stand-in: goes busy the cycle after a start strobe, stays busy busy_len cycles.
  initial begin
    tx_active = 1'b0;
    forever begin
      @(negedge clk);
      if (hold_busy) tx_active = 1'b1;
      else if (tx_dv) begin
        @(negedge clk);
        tx_active = 1'b1;
        repeat (busy_len) @(negedge clk);
        tx_active = 1'b0;
      end else tx_active = 1'b0;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void model_byte(input logic [7:0] b, input bit eof, input bit hex);
    if (!hex) begin
      exp_q.push_back(b);
      return;
    end
    exp_q.push_back(hexdig[int'(b[7:4])]);
    exp_q.push_back(hexdig[int'(b[3:0])]);
    m_line = m_line + 1;
    if ((EOF_EN && eof) || m_line == BPL) begin
      exp_q.push_back(8'h0d);
      exp_q.push_back(8'h0a);
      m_line = 0;
    end else begin
      exp_q.push_back(8'h20);
    end
  endfunction

  task automatic capture(input logic [7:0] d, input bit eof);
    in_d   = d;
    in_eof = eof;
    in_rdy = 1'b1;
    @(posedge clk); #1;
    in_rdy = 1'b0;
    in_eof = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_rx(input int unsigned n, input string name);
    int unsigned cyc = 0;
    while (rx.size() < n && cyc < 1000) begin
      @(posedge clk);
      cyc++;
    end
    if (rx.size() < n) check({name, "_timeout"}, rx.size(), n);
    repeat (12) @(posedge clk);
    #1;
    check({name, "_count"}, rx.size(), n);
  endtask

  initial begin
    logic [7:0]  d;
    bit          e;
    int unsigned k;
    int unsigned cyc;

    vecs[0]  = '{8'h5a, 1'b0, 1'b0, 1, 32'h5a000000};
    vecs[1]  = '{8'hc3, 1'b0, 1'b0, 1, 32'hc3000000};
    vecs[2]  = '{8'h0f, 1'b0, 1'b1, 3, 32'h30662000};
    vecs[3]  = '{8'hab, 1'b1, 1'b1, 4, 32'h61620d0a};
    vecs[4]  = '{8'h01, 1'b0, 1'b1, 3, 32'h30312000};
    vecs[5]  = '{8'h02, 1'b0, 1'b1, 4, 32'h30320d0a};
    vecs[6]  = '{8'h03, 1'b0, 1'b1, 3, 32'h30332000};
    vecs[7]  = '{8'hff, 1'b1, 1'b0, 1, 32'hff000000};
    vecs[8]  = '{8'h9c, 1'b0, 1'b1, 4, 32'h39630d0a};
`ifdef HEXDUMP_EOF_EN
    vecs[9]  = '{8'he7, 1'b1, 1'b1, 4, 32'h65370d0a};
    vecs[10] = '{8'h4d, 1'b0, 1'b1, 3, 32'h34642000};
    vecs[11] = '{8'h10, 1'b0, 1'b1, 4, 32'h31300d0a};
`else
    vecs[9]  = '{8'he7, 1'b1, 1'b1, 3, 32'h65372000};
    vecs[10] = '{8'h4d, 1'b0, 1'b1, 4, 32'h34640d0a};
    vecs[11] = '{8'h10, 1'b0, 1'b1, 3, 32'h31302000};
`endif

    reset = 1'b1; in_rdy = 1'b0; in_d = '0; in_eof = 1'b0; hex_mode = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("rst_tx_dv", {31'd0, tx_dv}, 0);
    check("rst_tx_d", {24'd0, tx_d}, 0);
    check("rst_fill", {29'd0, fill}, 0);
    check("rst_overflow", {31'd0, overflow}, 0);
    check("rst_drop", {16'd0, drop_count}, 0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    // Capture-to-strobe latency, then an asynchronous reset inside the SEND cycle.
    rx.delete();
    in_d = 8'h5a; in_rdy = 1'b1;
    @(posedge clk); #1;
    in_rdy = 1'b0;
    check("lat_fill_n", {29'd0, fill}, 1);
    check("lat_dv_n", {31'd0, tx_dv}, 0);
    @(posedge clk); #1;
    check("lat_fill_n1", {29'd0, fill}, 0);
    check("lat_dv_n1", {31'd0, tx_dv}, 0);
    @(posedge clk); #1;
    check("lat_dv_n2", {31'd0, tx_dv}, 1);
    check("lat_d_n2", {24'd0, tx_d}, 32'h5a);
    #1 reset = 1'b1;
    #1;
    check("async_rst_dv", {31'd0, tx_dv}, 0);
    check("async_rst_d", {24'd0, tx_d}, 0);
    @(negedge clk) reset = 1'b0;
    repeat (5) @(posedge clk); #1;
    check("async_rst_nochar", rx.size(), 0);

    for (int vi = 0; vi < 12; vi++) begin
      rx.delete();
      hex_mode = vecs[vi].hex;
      capture(vecs[vi].d, vecs[vi].eof);
      wait_rx(vecs[vi].n, $sformatf("vec%0d", vi));
      for (int i = 0; i < int'(vecs[vi].n); i++)
        check($sformatf("vec%0d_c%0d", vi, i), {24'd0, rx[i]}, {24'd0, vecs[vi].chars[31-8*i -: 8]});
    end

    // Held ready gives one capture; then overflow with the UART held busy.
    hex_mode = 1'b0;
    rx.delete();
    hold_busy = 1'b1;
    repeat (2) @(posedge clk); #1;
    in_d = 8'h11; in_rdy = 1'b1;
    repeat (100) @(posedge clk); #1;
    in_rdy = 1'b0;
    @(posedge clk); #1;
    check("hold_fill", {29'd0, fill}, 1);
    check("hold_drop", {16'd0, drop_count}, 0);
    capture(8'h22, 1'b0);
    capture(8'h33, 1'b0);
    capture(8'h44, 1'b0);
    capture(8'h55, 1'b0);
    capture(8'h66, 1'b0);
    check("ovf_fill", {29'd0, fill}, 4);
    check("ovf_drop", {16'd0, drop_count}, 2);
    check("ovf_flag", {31'd0, overflow}, 1);
    hold_busy = 1'b0;
    wait_rx(4, "ovf_drain");
    check("ovf_c0", {24'd0, rx[0]}, 32'h11);
    check("ovf_c1", {24'd0, rx[1]}, 32'h22);
    check("ovf_c2", {24'd0, rx[2]}, 32'h33);
    check("ovf_c3", {24'd0, rx[3]}, 32'h44);
    check("ovf_sticky", {31'd0, overflow}, 1);
    check("ovf_fill_end", {29'd0, fill}, 0);

    // Reset while the first hex character is waiting for tx_active to fall.
    hex_mode = 1'b1;
    busy_len = 6;
    rx.delete();
    capture(8'h3c, 1'b0);
    cyc = 0;
    while ((rx.size() < 1 || !tx_active) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 200) check("wlo_timeout", cyc, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("wlo_dv", {31'd0, tx_dv}, 0);
    check("wlo_fill", {29'd0, fill}, 0);
    check("wlo_overflow", {31'd0, overflow}, 0);
    check("wlo_drop", {16'd0, drop_count}, 0);
    @(negedge clk) reset = 1'b0;
    repeat (60) @(posedge clk); #1;
    check("wlo_count", rx.size(), 1);
    check("wlo_c0", {24'd0, rx[0]}, 32'h33);

    m_line = 0;
    for (int b = 0; b < 40; b++) begin
      rx.delete();
      exp_q.delete();
      hex_mode = 1'($urandom_range(0, 1));
      busy_len = $urandom_range(1, 4);
      k = $urandom_range(1, 4);
      for (int j = 0; j < int'(k); j++) begin
        d = 8'($urandom);
        e = 1'($urandom_range(0, 1));
        model_byte(d, e, hex_mode);
        capture(d, e);
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
      wait_rx(exp_q.size(), $sformatf("rnd%0d", b));
      for (int i = 0; i < exp_q.size(); i++)
        check($sformatf("rnd%0d_c%0d", b, i), {24'd0, rx[i]}, {24'd0, exp_q[i]});
    end
    check("rnd_drop", {16'd0, drop_count}, 0);
    check("rnd_overflow", {31'd0, overflow}, 0);
    check("rnd_fill", {29'd0, fill}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mii_hex_dumper.md
# mii_hex_dumper

Parametrised byte-stream capture buffer and UART formatter for the MII capture path. Captures bytes from an MII receive core on the rising edge of its ready level, buffers them in a configurable-depth FIFO and streams them to a byte-wide UART transmitter. Output is either raw bytes or lowercase ASCII hex with spaces, line wrapping and end-of-frame line breaks. Overflow is counted rather than silently lost.

## Interface

Parameters:
- DEPTH_LOG2, 6, FIFO depth is 2**DEPTH_LOG2 entries; legal range 2..10
- BYTES_PER_LINE, 16, hex-mode bytes per output line before CR LF; legal range 1..255

Ports:
- clk  in  1  system clock; all logic on posedge
- reset  in  1  asynchronous, active-high; clears all state
- in_rdy  in  1  byte-valid level from the MII core; a byte is captured on each 0->1 transition
- in_d  in  8  byte, valid while in_rdy is high
- in_eof  in  1  when high in the capture cycle, tags the captured byte as the last byte of a frame
- hex_mode  in  1  1 = ASCII hex dump, 0 = raw bytes; sampled on each FIFO pop
- tx_dv  out  1  one-cycle start strobe to the UART transmitter
- tx_d  out  8  character to send, stable from tx_dv until the next tx_dv
- tx_active  in  1  UART busy flag
- fill  out  DEPTH_LOG2+1  current FIFO occupancy
- overflow  out  1  sticky; set on the first dropped byte
- drop_count  out  16  dropped bytes, saturating at 16'hffff

## Operation

- Write side:
  - in_rdy is registered as rdy_q; capture happens when in_rdy & ~rdy_q.
  - A capture writes the entry {in_eof, in_d} (9 bits) at wr_ptr and increments wr_ptr.
  - Capture while full: the entry is not written, drop_count increments (saturating) and overflow is set.
  - Full is evaluated before any same-cycle pop. A capture at full is therefore dropped even if a pop occurs in that cycle.
- Pointers are DEPTH_LOG2+1 bits and wrap naturally. Empty is ptrs equal. Full is MSBs differ and the rest are equal.
- Read FSM states:
  - IDLE: if not empty, pop the entry into {eof_r, byte_r}, latch hex_mode into mode_r, go to LOAD.
  - LOAD: choose the first character:
    - raw mode: byte_r
    - hex mode: hex of byte_r[7:4]
    - Then go to SEND.
  - SEND: assert tx_dv for one cycle with tx_d = current character, go to WAIT_HI.
  - WAIT_HI: wait for tx_active = 1, then go to WAIT_LO.
  - WAIT_LO: wait for tx_active = 0, then go to NEXT.
  - NEXT: select the next character, or return to IDLE.
    - raw mode: go to IDLE.
    - hex sequence: high nibble, low nibble, then a separator.
    - Separator is CR LF if eof_r is set or line_cnt+1 == BYTES_PER_LINE; otherwise it is a space (8'h20).
    - After CR LF, line_cnt resets to 0. After a space, line_cnt increments.
- Hex digits: 0-9 map to 8'h30-8'h39; a-f map to 8'h61-8'h66 (lowercase). CR is 8'h0d, LF is 8'h0a.
- Raw mode ignores eof_r and does not change line_cnt.
- A change of hex_mode takes effect at the next pop. The entry in flight completes in its latched mode.

## Timing

- Reset values:
  - tx_dv = 0, tx_d = 8'h00, fill = 0, overflow = 0, drop_count = 0
  - FSM in IDLE, line_cnt = 0, rdy_q = 0
- Capture at posedge N: fill updates after N. When the FSM is idle, it pops at N+1, and tx_dv is high in the cycle after N+2.
- tx_dv is never asserted while tx_active = 1. Two consecutive tx_dv pulses are separated by at least one observed high-then-low of tx_active.
- Continuous in_rdy high produces exactly one capture. The next capture needs in_rdy to go low for at least one cycle.
- Reset asserted mid-character:
  - tx_dv deasserts immediately and asynchronously.
  - FIFO contents become don't-care because the pointers are cleared.
  - Any partially sent hex sequence is abandoned.
- Simultaneous capture and pop when not full: both happen in the same cycle and fill is unchanged.

## Configuration

- HEXDUMP_EOF_EN defined:
  - FIFO entries are 9 bits.
  - in_eof tags bytes, and tagged bytes end their hex line with CR LF.
- HEXDUMP_EOF_EN undefined:
  - FIFO entries are 8 bits and in_eof is ignored.
  - Line breaks occur only at BYTES_PER_LINE.
  - The port list is identical in both builds.

## Test plan

- Raw mode with BYTES_PER_LINE=16: capture 8'h5a and 8'hc3 -> tx_d sequence 8'h5a, 8'hc3; two tx_dv pulses; fill returns to 0.
- Hex mode: capture 8'h0f then 8'hab with in_eof=1 (HEXDUMP_EOF_EN defined) -> "0","f"," ","a","b",CR,LF.
- Hex mode with BYTES_PER_LINE=2 and no eof: capture 8'h01, 8'h02, 8'h03 -> "01 02\r\n03 ".
- DEPTH_LOG2=2 with tx_active held high: capture 6 bytes -> fill=4, drop_count=2, overflow=1. Release tx_active -> the first 4 bytes are emitted in order.
- Hold in_rdy high for 100 cycles -> exactly one capture.
- Assert reset while in WAIT_LO -> tx_dv=0, fill=0, overflow=0 on the next sample, and no further tx_dv occurs until a new capture.
